vga_timing: RTL

//  Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock.

---
 rtl/vga_timing.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 Hz raster timing generator.
// A clock divider produces a one-clk pixel strobe; on each strobe the
// column/line counters step through the full raster (active + porches +
// sync). Sync and active flags are registered from the next-state
// counters so they change on the same edge as the coordinates they
// describe.
module vga_timing #(
  parameter int       CLK_DIV  = 4,
  parameter int       H_ACTIVE = 640,
  parameter int       H_FRONT  = 16,
  parameter int       H_SYNC   = 96,
  parameter int       H_BACK   = 48,
  parameter int       V_ACTIVE = 480,
  parameter int       V_FRONT  = 10,
  parameter int       V_SYNC   = 2,
  parameter int       V_BACK   = 33,
  parameter logic     SYNC_POL = 1'b0,
  parameter int       CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             pix_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // A divide-by-1 still needs a one-bit counter that simply stays at 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);

  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q,    div_d;
  logic             pix_en_q, pix_en_d;
  logic [CNT_W-1:0] h_q,      h_d;
  logic [CNT_W-1:0] v_q,      v_d;
  logic             hsync_q,  hsync_d;
  logic             vsync_q,  vsync_d;
  logic             active_q, active_d;

  // Divider: counts while enabled; the strobe is raised for the cycle that
  // follows the terminal count, so the first strobe lands CLK_DIV clks after
  // the counter starts from 0.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    div_d    = div_q;
    pix_en_d = 1'b0;
    if (en) begin
      pix_en_d = (div_q == DIV_LAST);
      div_d    = pix_en_d ? '0 : div_q + 1'b1;
    end
  end

  // Raster counters: step once at the end of each strobe cycle. The step
  // keys off the registered strobe, so an en drop in a strobe cycle still
  // lets that pixel's step (and any wrap) complete.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Sync/active decode from the next-state counters, so the registered
  // flags line up with the registered coordinates with no skew.
  always_comb begin
    hsync_d  = ((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = ((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    active_d = (h_d < H_ACT_END) && (v_d < V_ACT_END);
  end

  // State registers; reset puts the raster at (0,0), which is visible and
  // outside both sync windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      active_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking ones would make the result order-dependent.
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign h_count     = h_q;
  assign v_count     = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  // Start markers are pure decodes of registers, so they drop with the
  // strobe and clear asynchronously with reset.
  assign line_start  = pix_en_q & (h_q == '0);
  assign frame_start = pix_en_q & (h_q == '0) & (v_q == '0);

endmodule
